// File: rtl/alu_acc_sequencer.sv
// Accumulator sequencer wrapped around a combinational 4-bit ALU: accepts a command, waits for the
// ripple logic to settle, captures the result into the accumulator and returns it with flags.
module alu_acc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  ACC_RESET     = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [0:3] cmd_b,
  output logic [0:3] alu_a,
  output logic [0:3] alu_b,
  output logic       alu_c0,
  output logic       alu_c1,
  input  logic [0:3] alu_y,
  input  logic [0:3] alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [0:3] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(SETTLE_EFF + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  // Index 0 is the LSB on every [0:3] bus, so the reset constant is re-ordered bit by bit.
  localparam logic [0:3] ACC_INIT = {ACC_RESET[0], ACC_RESET[1], ACC_RESET[2], ACC_RESET[3]};

  logic [1:0]       state_q, state_d;
  logic [0:3]       acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [0:3]       b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_INIT;
      op_q        <= 3'b000;
      b_q         <= 4'b0000;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state and datapath; LOAD/reserved pass through SETTLE for one edge so every
  // command answers at least one edge after it is accepted.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          b_d     = cmd_b;
          cnt_d   = cmd_op[2] ? CNT_W'(1) : CNT_W'(SETTLE_EFF);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          carry_d = 1'b0;
          err_d   = 1'b0;
          if (!op_q[2]) begin
            acc_d   = (op_q == OP_XNOR) ? alu_z : alu_y;
            carry_d = (op_q == OP_ADD) && alu_z[3];
          end else if (op_q == OP_LOAD) begin
            acc_d = b_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_c0    = op_q[0];
  assign alu_c1    = op_q[1];
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_carry = carry_q;
  assign res_err   = err_q;
  assign res_zero  = res_valid_q && (acc_q == 4'b0000);

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: a 4-bit ripple ALU stand-in on the alu_* pins, directed spec cases,
// backpressure, reset mid-operation, random commands against an arithmetic accumulator model.
module tb_alu_acc_sequencer;

  localparam int S_MAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_ready, res_valid, res_ready;
  logic [2:0] cmd_op;
  logic [0:3] cmd_b, alu_a, alu_b, alu_y, alu_z, res_data;
  logic       alu_c0, alu_c1, res_carry, res_zero, res_err;
  logic [7:0] yz;

  logic       d0_cmd_valid, d0_cmd_ready, d0_res_valid, d0_res_ready;
  logic [2:0] d0_cmd_op;
  logic [0:3] d0_cmd_b, d0_alu_a, d0_alu_b, d0_alu_y, d0_alu_z, d0_res_data;
  logic       d0_alu_c0, d0_alu_c1, d0_res_carry, d0_res_zero, d0_res_err;
  logic [7:0] d0_yz;

  int n_vec = 0;
  int n_err = 0;
  int m_acc = 0;

  int dir_op [13] = '{4, 0, 4, 1, 4, 2, 4, 3, 4, 0, 6, 4, 5};
  int dir_b  [13] = '{11, 7, 12, 10, 5, 0, 12, 10, 9, 7, 3, 15, 2};
  int dir_d  [13] = '{11, 2, 12, 8, 5, 10, 12, 9, 9, 0, 0, 15, 15};
  int dir_c  [13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int dir_e  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

  function automatic logic [3:0] num(input logic [0:3] v);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) n[i] = v[i];
    return n;
  endfunction

  function automatic logic [0:3] pins(input logic [3:0] n);
    logic [0:3] p;
    for (int i = 0; i < 4; i++) p[i] = n[i];
    return p;
  endfunction

  // Ripple ALU stand-in; returns {y, z} as numbers. y/z for unused slots differ on purpose.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic c1, input logic c0);
    logic [3:0] y, z;
    logic       c;
    c = 1'b0;
    y = 4'h0;
    z = 4'h0;
    for (int i = 0; i < 4; i++) begin
      y[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      z[i] = c;
    end
    case ({c1, c0})
      2'b00:   ;
      2'b01:   begin y = a & b; z = ~(a ^ b); end
      2'b10:   begin y = ~a;    z = ~(a ^ b); end
      default: begin y = a | b; z = ~(a ^ b); end
    endcase
    return {y, z};
  endfunction

  assign yz       = alu_fn(num(alu_a), num(alu_b), alu_c1, alu_c0);
  assign alu_y    = pins(yz[7:4]);
  assign alu_z    = pins(yz[3:0]);
  assign d0_yz    = alu_fn(num(d0_alu_a), num(d0_alu_b), d0_alu_c1, d0_alu_c0);
  assign d0_alu_y = pins(d0_yz[7:4]);
  assign d0_alu_z = pins(d0_yz[3:0]);

  alu_acc_sequencer #(.SETTLE_CYCLES(S_MAIN), .ACC_RESET(4'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c0(alu_c0), .alu_c1(alu_c1), .alu_y(alu_y), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err)
  );

  alu_acc_sequencer #(.SETTLE_CYCLES(0), .ACC_RESET(4'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(d0_cmd_valid), .cmd_ready(d0_cmd_ready),
    .cmd_op(d0_cmd_op), .cmd_b(d0_cmd_b), .alu_a(d0_alu_a), .alu_b(d0_alu_b),
    .alu_c0(d0_alu_c0), .alu_c1(d0_alu_c1), .alu_y(d0_alu_y), .alu_z(d0_alu_z),
    .res_valid(d0_res_valid), .res_ready(d0_res_ready), .res_data(d0_res_data),
    .res_carry(d0_res_carry), .res_zero(d0_res_zero), .res_err(d0_res_err)
  );

  // Reference: accumulator semantics in plain integer arithmetic.
  task automatic model_step(input int op, input int b, output int d, output int c,
                            output int z, output int e, output int lat);
    int r;
    c = 0;
    e = 0;
    case (op)
      0: begin r = m_acc + b; c = (r > 15) ? 1 : 0; m_acc = r % 16; end
      1: m_acc = m_acc & b;
      2: m_acc = 15 - m_acc;
      3: m_acc = 15 - (m_acc ^ b);
      4: m_acc = b;
      default: e = 1;
    endcase
    d   = m_acc;
    z   = (m_acc == 0) ? 1 : 0;
    lat = (op <= 3) ? S_MAIN : 1;
  endtask

  // Starts at a negedge; returns after the first negedge where res_valid is seen (bounded).
  task automatic send(input int op, input int b, output int lat, output int d,
                      output int c, output int z, output int e);
    int w;
    cmd_op    = 3'(op);
    cmd_b     = pins(4'(b));
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    d = int'(num(res_data));
    c = int'(res_carry);
    z = int'(res_zero);
    e = int'(res_err);
  endtask

  task automatic take_result;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] got, want;
    int lat, d, c, z, e, md, mc, mz, me, ml;
    want = {7'b1000000, 8'h00};
    repeat (2) @(negedge clk);
    got = {cmd_ready, res_valid, res_carry, res_zero, res_err, alu_c1, alu_c0, num(alu_a), num(alu_b)};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_state got %h want %h", got, want); end
    rst_n = 1'b1;
    @(negedge clk);
    send(4, 5, lat, d, c, z, e);
    model_step(4, 5, md, mc, mz, me, ml);
    take_result();
    // Start an ADD and pull reset while it is still settling.
    cmd_op = 3'(0); cmd_b = pins(4'(3)); cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      n_err++; $display("FAIL async_reset ready/valid got %b want 10", {cmd_ready, res_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {cmd_ready, res_valid, res_carry, res_zero, res_err, alu_c1, alu_c0, num(alu_a), num(alu_b)};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_mid_settle got %h want %h", got, want); end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      n_err++; $display("FAIL dropped_cmd ready/valid got %b want 10", {cmd_ready, res_valid});
    end
    m_acc = 0;
  endtask

  task automatic test_directed;
    logic [11:0] got, want;
    int lat, d, c, z, e, md, mc, mz, me, ml;
    for (int i = 0; i < 13; i++) begin
      send(dir_op[i], dir_b[i], lat, d, c, z, e);
      model_step(dir_op[i], dir_b[i], md, mc, mz, me, ml);
      got  = {4'(d), 1'(c), 1'(z), 1'(e), 5'(lat)};
      want = {4'(dir_d[i]), 1'(dir_c[i]), 1'(dir_d[i] == 0), 1'(dir_e[i]), 5'(dir_op[i] <= 3 ? S_MAIN : 1)};
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL directed[%0d] {data,c,z,e,lat} got %h want %h", i, got, want);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] got, want;
    logic [8:0]  snap, obs;
    int lat, d, c, z, e, md, mc, mz, me, ml;
    send(0, 3, lat, d, c, z, e);
    model_step(0, 3, md, mc, mz, me, ml);
    got  = {4'(d), 1'(c), 1'(z), 1'(e), 5'(lat)};
    want = {4'(md), 1'(mc), 1'(mz), 1'(me), 5'(ml)};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL bp_result got %h want %h", got, want); end
    snap = {2'b10, num(res_data), res_carry, res_zero, res_err};
    cmd_op = 3'(4); cmd_b = pins(4'(6)); cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      obs = {res_valid, cmd_ready, num(res_data), res_carry, res_zero, res_err};
      n_vec++;
      if (obs !== snap) begin n_err++; $display("FAIL bp_hold[%0d] got %h want %h", k, obs, snap); end
    end
    take_result();
    n_vec++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release valid/ready got %b want 01", {res_valid, cmd_ready});
    end
    send(4, 6, lat, d, c, z, e);
    model_step(4, 6, md, mc, mz, me, ml);
    got  = {4'(d), 1'(c), 1'(z), 1'(e), 5'(lat)};
    want = {4'(md), 1'(mc), 1'(mz), 1'(me), 5'(ml)};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL bp_pending got %h want %h", got, want); end
    take_result();
  endtask

  task automatic test_random;
    logic [15:0] got, want;
    int op, b, lat, d, c, z, e, md, mc, mz, me, ml;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      b  = int'($urandom_range(0, 15));
      send(op, b, lat, d, c, z, e);
      model_step(op, b, md, mc, mz, me, ml);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      got  = {4'(d), 1'(c), 1'(z), 1'(e), 5'(lat), num(alu_a)};
      want = {4'(md), 1'(mc), 1'(mz), 1'(me), 5'(ml), 4'(md)};
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL random[%0d] op=%0d b=%0d got %h want %h", i, op, b, got, want);
      end
      take_result();
    end
  endtask

  task automatic test_settle_zero;
    int t_op [3] = '{4, 0, 0};
    int t_b  [3] = '{4, 5, 8};
    int t_d  [3] = '{4, 9, 1};
    int t_c  [3] = '{0, 0, 1};
    logic [5:0] got, want;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d0_cmd_op = 3'(t_op[i]); d0_cmd_b = pins(4'(t_b[i])); d0_cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d0_cmd_valid = 1'b0;
      n_vec++;
      if (d0_res_valid !== 1'b0) begin
        n_err++; $display("FAIL s0_early[%0d] res_valid got %b want 0", i, d0_res_valid);
      end
      @(posedge clk);
      @(negedge clk);
      got  = {d0_res_valid, d0_res_carry, num(d0_res_data)};
      want = {1'b1, 1'(t_c[i]), 4'(t_d[i])};
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL s0_result[%0d] got %h want %h", i, got, want); end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = 3'b000;
    cmd_b        = 4'b0000;
    res_ready    = 1'b0;
    d0_cmd_valid = 1'b0;
    d0_cmd_op    = 3'b000;
    d0_cmd_b     = 4'b0000;
    d0_res_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_settle_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
